rx_frame_reader: RTL and testbench

RX_FRAME_READER -- requirements
Module: rx_frame_reader

---
 rtl/vthernet_pkg.sv | 14 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/rx_frame_reader.sv | 160 ++++++++++++++++
 tb/tb_rx_frame_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/vthernet_pkg.sv
// Shared definitions for the RX frame reader: FSM state encoding and default
// pipeline/buffer sizing.
package vthernet_pkg;

  localparam int RD_LAT_DEFAULT     = 3;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous flush.
// The head entry is presented combinationally whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !clr));

endmodule

// File: rtl/rx_frame_reader.sv
// Streams a frame of bytes out of a fixed-latency SRAM read port into a
// ready/valid byte stream, with credit-based read issue into a small FIFO.
//
// state    | meaning
// ST_IDLE  | waiting for start; first read is issued on the accepting edge
// ST_READ  | issuing reads while FIFO credit allows
// ST_DRAIN | all reads issued, waiting for the last byte to be accepted
module rx_frame_reader
  import vthernet_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = RD_LAT_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   frame_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rd_addr_nx;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH:0]   rd_left;
  logic [ADDR_WIDTH:0]   rd_left_nx;
  logic [ADDR_WIDTH:0]   out_left;
  logic [RD_LAT-1:0]     vld_sr;
  logic                  issue;
  logic                  accept;
  logic                  frame_done;
  logic                  pop;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         in_flight;
  logic [SW-1:0]         credit;
  logic [DATA_WIDTH-1:0] head;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort),
    .push      (vld_sr[RD_LAT-1]),
    .push_data (sram_dout1),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : head;
  assign m_last  = !fifo_empty && (out_left == LEN_ONE);
  assign pop     = m_valid && m_ready;
  assign busy    = (state != ST_IDLE);

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + SW'(vld_sr[i]);
  end

  // The byte leaving this cycle frees its slot, which keeps one read per
  // cycle flowing with a shallow FIFO while still never overfilling it.
  assign credit = SW'(fifo_count) + in_flight - SW'(pop);

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_addr = rd_addr;
    rd_addr_nx = rd_addr;
    rd_left_nx = rd_left;
    accept     = 1'b0;
    frame_done = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (frame_len == '0) begin
              frame_done = 1'b1;
            end else begin
              accept     = 1'b1;
              issue      = 1'b1;
              issue_addr = start_addr;
              rd_addr_nx = start_addr + ADDR_ONE;
              rd_left_nx = frame_len - LEN_ONE;
              state_nx   = (frame_len == LEN_ONE) ? ST_DRAIN : ST_READ;
            end
          end
        end
        ST_READ: begin
          if (int'(credit) < FIFO_DEPTH) begin
            issue      = 1'b1;
            issue_addr = rd_addr;
            rd_addr_nx = rd_addr + ADDR_ONE;
            rd_left_nx = rd_left - LEN_ONE;
            if (rd_left == LEN_ONE) state_nx = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && out_left == LEN_ONE) begin
            frame_done = 1'b1;
            state_nx   = ST_IDLE;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb1  <= 1'b1;
      sram_addr1 <= '0;
      rd_addr    <= '0;
      rd_left    <= '0;
      out_left   <= '0;
      vld_sr     <= '0;
      done       <= 1'b0;
    end else begin
      sram_csb1 <= !issue;
      if (issue) sram_addr1 <= issue_addr;
      rd_addr   <= rd_addr_nx;
      rd_left   <= rd_left_nx;
      done      <= frame_done;
      vld_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= abort ? 1'b0 : vld_sr[i-1];
      if (accept)   out_left <= frame_len;
      else if (pop) out_left <= out_left - LEN_ONE;
    end
  end

endmodule

// File: tb/tb_rx_frame_reader.sv
// Randomized self-checking bench for rx_frame_reader: a behavioural SRAM,
// and per-frame expectations computed from start address, length and memory.
module tb_rx_frame_reader;

  localparam int AW     = 10;
  localparam int DW     = 8;
  localparam int RD_LAT = 3;
  localparam int DEPTH  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   frame_len = '0;
  logic          busy;
  logic          done;
  logic          sram_csb1;
  logic          m_valid;
  logic          m_last;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1 = '0;
  logic [DW-1:0] m_data;

  logic [DW-1:0] mem [1 << AW];
  logic          s_v = 1'b0;
  logic [AW-1:0] s_a = '0;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  rx_frame_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .frame_len  (frame_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  // Read port: a request launched at edge N returns data valid before edge N+3;
  // between returns the port shows junk so that a mistimed capture is visible.
  always @(posedge clk) begin
    s_v        <= !sram_csb1;
    s_a        <= sram_addr1;
    sram_dout1 <= s_v ? mem[s_a] : DW'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_frame(input logic [AW-1:0] addr, input logic [AW:0] len,
                           input bit rnd_ready, input int abort_at);
    int            cyc, idx, nrd, dones, first_v, last_x, exp_done;
    bit            fin;
    logic [AW-1:0] a;
    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    frame_len  = len;
    m_ready    = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0; idx = 0; nrd = 0; dones = 0; first_v = -1; last_x = -1; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start   = 1'b0;
      abort   = 1'b0;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == 2 && len != 0) begin
        start      = 1'b1;
        start_addr = addr ^ 10'h155;
        frame_len  = 11'd7;
      end
      if (abort_at >= 0 && idx == abort_at) begin
        abort   = 1'b1;
        m_ready = 1'b0;
      end
      if (cyc == 1) check("busy_start", busy, len != 0);
      if (len == 0) check("zl_csb", sram_csb1, 1);
      if (!sram_csb1) begin
        a = addr + AW'(nrd);
        check("rd_addr", sram_addr1, a);
        nrd++;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        a = addr + AW'(idx);
        check("data", m_data, mem[a]);
        check("last", m_last, idx == int'(len) - 1);
        last_x = cyc;
        idx++;
      end
      if (done) begin
        dones++;
        exp_done = (len == 0) ? 1 : last_x + 1;
        check("done_time", cyc, exp_done);
        check("busy_end", busy, 0);
        fin = 1'b1;
      end
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", m_valid, 0);
        check("abort_csb", sram_csb1, 1);
        repeat (4) begin
          @(negedge clk);
          check("abort_nodone", done, 0);
          check("abort_quiet", m_valid, 0);
        end
        check("abort_done_cnt", dones, 0);
        fin = 1'b1;
      end
      if (!fin && cyc > 6000) begin
        check("frame_timeout", idx, int'(len));
        fin = 1'b1;
      end
    end
    if (abort_at < 0) begin
      check("n_bytes", idx, int'(len));
      check("n_reads", nrd, int'(len));
      check("n_done", dones, 1);
      if (!rnd_ready && len != 0) begin
        check("first_valid", first_v, RD_LAT + 1);
        check("stream_span", last_x - first_v, int'(len) - 1);
      end
      @(negedge clk);
      check("done_pulse", done, 0);
    end
    m_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[16] = 8'hA1;
    mem[17] = 8'hB2;
    mem[18] = 8'hC3;
    mem[19] = 8'hD4;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_csb", sram_csb1, 1);
    check("rst_addr", sram_addr1, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    rst_n = 1'b1;

    run_frame(10'h010, 11'd4, 1'b0, -1);
    run_frame(10'h3FE, 11'd4, 1'b0, -1);
    run_frame(10'h000, 11'd0, 1'b0, -1);
    run_frame(AW'($urandom), 11'd64, 1'b1, -1);
    run_frame(AW'($urandom), 11'd100, 1'b0, 10);
    run_frame(AW'($urandom), 11'd2, 1'b0, -1);

    // Reset dropped in the middle of a frame.
    @(negedge clk);
    start = 1'b1; start_addr = 10'h200; frame_len = 11'd50; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_csb", sram_csb1, 1);
    check("arst_addr", sram_addr1, 0);
    check("arst_valid", m_valid, 0);
    check("arst_last", m_last, 0);
    check("arst_data", m_data, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b0;
    run_frame(AW'($urandom), 11'd20, 1'b1, -1);

    for (int k = 0; k < 8; k++)
      run_frame(AW'($urandom), 11'($urandom_range(1, 48)), k[0], -1);
    run_frame(AW'($urandom), 11'd1, 1'b0, -1);
    run_frame(AW'($urandom), 11'd1024, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
